fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives the instruction-memory address.
- Applies stalls from the hazard unit and applies branch/jump redirects resolved in ID, with one architectural delay slot.
- Detects illegal fetch addresses and freezes in a sticky fault state.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch byte address.
- IM_WORDS, 4096, instruction-memory depth in 32-bit words; legal range is [IM_BASE, IM_BASE + 4*IM_WORDS).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; hold the PC this cycle.
- jump_signal_id  in  3  ID-stage control: 0 none, 1 conditional branch, 2 j/jal, 3 jr/jalr, 4-7 treated as 0.
- branch_taken_id  in  1  comparator result for a conditional branch in ID.
- pc_id  in  32  PC of the instruction in ID.
- addr16_id  in  16  branch offset field.
- addr26_id  in  26  jump index field.
- rs_value_id  in  32  forwarded rs value for jr/jalr.
- instr_addr  out  32  instruction-memory address, equal to pc (combinational read).
- pc_if  out  32  PC handed to the IF/ID register.
- valid_if  out  1  1 means the fetched word is real; 0 means the IF/ID register must load a bubble.
- if_reg_enable  out  1  IF/ID register enable; equals ~stall.
- fault  out  1  sticky fetch-fault flag.
- fault_pc  out  32  offending target address latched on fault entry.

Behaviour:
- Reset:
  - pc=RESET_PC, state=RUN, fault=0, fault_pc=0.
  - valid_if=1 from the first cycle after reset.
  - Reset asserted mid-operation (including in FAULT) takes effect at the next edge and overrides all other inputs.
- Combinational outputs: instr_addr=pc_if=pc; if_reg_enable=~stall.
- Redirect condition: (jump_signal_id==1 && branch_taken_id) || jump_signal_id==2 || jump_signal_id==3.
- Redirect target:
  - Branch: pc_id + 4 + (sign_extend(addr16_id) << 2), 32-bit wrap-around arithmetic.
  - j/jal: {pc_id[31:28], addr26_id, 2'b00}.
  - jr/jalr: rs_value_id.
- Delay slot: the instruction in IF while a redirect sits in ID is the delay slot. It is never squashed. The redirect target is loaded as the next PC.
- next_pc = redirect ? target : pc + 4.
- State RUN, each clock edge:
  - If stall: pc holds. Redirect is ignored, because the branch stays in ID and re-evaluates next cycle. Stall has priority over a simultaneous redirect.
  - Else if next_pc is misaligned (low 2 bits != 0) or outside the legal range: go to FAULT. pc holds. fault_pc <= next_pc. fault <= 1.
  - Else: pc <= next_pc.
- State FAULT:
  - pc frozen; valid_if=0; fault=1; all inputs ignored.
  - Exits only on reset.
- Out-of-range check: compare the full 32-bit address against IM_BASE and IM_BASE + 4*IM_WORDS using 33-bit arithmetic, so the upper bound does not overflow.
- The pc register itself never holds an illegal value after reset.

Optional Feature:
- Macro: FETCH_COUNTER_EN.
- When defined:
  - Adds output fetch_count (32 bits).
  - Reset value 0.
  - Increments by 1 on every edge with state==RUN, stall==0 and a legal next_pc.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Holds in FAULT.
- When undefined: no port and no counter logic.

Test Plan:
- Reset then 3 unstalled cycles -> pc 3000, 3004, 3008, 300C; valid_if=1; fault=0.
- At pc=3010, pc_id=300C, jump_signal_id=1, branch_taken_id=1, addr16_id=16'hFFFC -> next pc=3000. The delay slot at 3010 is fetched first and not squashed.
- At pc=3020: stall=1 for 2 cycles with jump_signal_id=2, addr26_id=26'h0000C80 -> pc holds 3020 for 2 cycles, then loads 3200 on the first unstalled edge.
- jump_signal_id=3, rs_value_id=32'h0000_3002 -> enter FAULT; fault=1; fault_pc=3002; pc frozen; valid_if=0. Reset then returns pc=3000 with fault=0.
- jump_signal_id=3, rs_value_id=32'h0000_7000 (=IM_BASE+4*IM_WORDS with defaults) -> FAULT, fault_pc=7000. Target 6FFC -> accepted.
- FETCH_COUNTER_EN: 10 fetches with stall high on 3 of the cycles -> fetch_count=7. The count stops incrementing after a fault.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: owns the PC, applies stalls and ID-stage redirects (one delay slot),
// and freezes in a sticky fault state on an illegal fetch target. Optional macro: FETCH_COUNTER_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  jump_signal_id,
    input  logic        branch_taken_id,
    input  logic [31:0] pc_id,
    input  logic [15:0] addr16_id,
    input  logic [25:0] addr26_id,
    input  logic [31:0] rs_value_id,
    output logic [31:0] instr_addr,
    output logic [31:0] pc_if,
    output logic        valid_if,
    output logic        if_reg_enable,
    output logic        fault,
    output logic [31:0] fault_pc
`ifdef FETCH_COUNTER_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    // 33-bit upper bound so IM_BASE + 4*IM_WORDS cannot wrap
    localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] next_pc_s;
    logic        legal_s;
    logic        advance_s;

    // Redirect decode and target selection for the instruction sitting in ID
    always_comb begin
        redirect_s = 1'b0;
        target_s   = 32'h0000_0000;
        case (jump_signal_id)
            3'd1: begin
                redirect_s = branch_taken_id;
                target_s   = pc_id + 32'd4 + {{14{addr16_id[15]}}, addr16_id, 2'b00};
            end
            3'd2: begin
                redirect_s = 1'b1;
                target_s   = {pc_id[31:28], addr26_id, 2'b00};
            end
            3'd3: begin
                redirect_s = 1'b1;
                target_s   = rs_value_id;
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = 32'h0000_0000;
            end
        endcase
    end

    // Next sequential/redirected PC and its legality
    always_comb begin
        next_pc_s = redirect_s ? target_s : (pc_q + 32'd4);
        legal_s   = (next_pc_s[1:0] == 2'b00) &&
                    ({1'b0, next_pc_s} >= IM_LO) &&
                    ({1'b0, next_pc_s} <  IM_HI);
    end

    // FSM next-state: stall beats redirect; an illegal target freezes the PC
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        advance_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (!legal_s) begin
                    state_d    = ST_FAULT;
                    fault_pc_d = next_pc_s;
                end else begin
                    pc_d      = next_pc_s;
                    advance_s = 1'b1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State, PC and fault-address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

`ifdef FETCH_COUNTER_EN
    logic [31:0] fetch_count_q;

    // Counts accepted fetch advances, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'h0000_0000;
        end else if (advance_s) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end else begin
            fetch_count_q <= fetch_count_q;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

    assign instr_addr    = pc_q;
    assign pc_if         = pc_q;
    assign valid_if      = (state_q == ST_RUN);
    assign fault         = (state_q == ST_FAULT);
    assign fault_pc      = fault_pc_q;
    assign if_reg_enable = ~stall;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, corner sequences, and
// randomized traffic against a behavioural model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] BASE    = 32'h0000_3000;
    localparam int          NWORDS  = 4096;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken_id;
    logic [2:0]  jump_signal_id;
    logic [31:0] pc_id, rs_value_id;
    logic [15:0] addr16_id;
    logic [25:0] addr26_id;
    logic [31:0] instr_addr, pc_if, fault_pc;
    logic        valid_if, if_reg_enable, fault;
`ifdef FETCH_COUNTER_EN
    logic [31:0] fetch_count;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .jump_signal_id  (jump_signal_id),
        .branch_taken_id (branch_taken_id),
        .pc_id           (pc_id),
        .addr16_id       (addr16_id),
        .addr26_id       (addr26_id),
        .rs_value_id     (rs_value_id),
        .instr_addr      (instr_addr),
        .pc_if           (pc_if),
        .valid_if        (valid_if),
        .if_reg_enable   (if_reg_enable),
        .fault           (fault),
        .fault_pc        (fault_pc)
`ifdef FETCH_COUNTER_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [2:0]  js;
        logic        bt;
        logic [31:0] pc_id;
        logic [15:0] a16;
        logic [25:0] a26;
        logic [31:0] rs;
        logic [31:0] e_pc;
        logic        e_fault;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t vecs[15];

    // behavioural model state
    logic [31:0] m_pc, m_fpc, m_cnt;
    logic        m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; jump_signal_id = 3'd0; branch_taken_id = 1'b0;
        pc_id = 32'h0; addr16_id = 16'h0; addr26_id = 26'h0; rs_value_id = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc,
                               input logic e_fault, input logic [31:0] e_fpc);
        check({tag, ".pc_if"},      pc_if, e_pc);
        check({tag, ".instr_addr"}, instr_addr, e_pc);
        check({tag, ".fault"},      32'(fault), 32'(e_fault));
        check({tag, ".valid_if"},   32'(valid_if), 32'(!e_fault));
        check({tag, ".fault_pc"},   fault_pc, e_fpc);
    endtask

    // Reference: apply the architectural rules to the model for one edge
    task automatic model_step();
        logic [31:0] nxt;
        logic        redir;
        int          off;
        longint      lo, hi;
        if (reset) begin
            m_pc = RST_PC; m_fault = 1'b0; m_fpc = 32'h0; m_cnt = 32'h0;
            return;
        end
        if (m_fault || stall) return;
        redir = 1'b0;
        nxt   = m_pc + 32'd4;
        if (jump_signal_id == 3'd1 && branch_taken_id) begin
            off   = int'($signed(addr16_id));
            nxt   = pc_id + 32'd4 + 32'(off * 4);
            redir = 1'b1;
        end else if (jump_signal_id == 3'd2) begin
            nxt   = (pc_id & 32'hF000_0000) + 32'(addr26_id) * 32'd4;
            redir = 1'b1;
        end else if (jump_signal_id == 3'd3) begin
            nxt   = rs_value_id;
            redir = 1'b1;
        end
        lo = longint'(BASE);
        hi = longint'(BASE) + 4 * NWORDS;
        if ((nxt % 4) == 0 && longint'(nxt) >= lo && longint'(nxt) < hi) begin
            m_pc  = nxt;
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_fault = 1'b1;
            m_fpc   = nxt;
        end
        if (redir) begin end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        //                 stl js   bt   pc_id          a16       a26          rs             e_pc          flt  e_fpc
        vecs[0]  = '{1'b0, 3'd0, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0000_3004, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'd0, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0000_3008, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 3'd0, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0000_300C, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 3'd0, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0000_3010, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 3'd1, 1'b1, 32'h0000_300C, 16'hFFFC, 26'h0,       32'h0,         32'h0000_3000, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 3'd1, 1'b0, 32'h0000_3000, 16'h0040, 26'h0,       32'h0,         32'h0000_3004, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 3'd3, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0000_3020, 32'h0000_3020, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 3'd2, 1'b0, 32'h0000_301C, 16'h0,    26'h0000C80, 32'h0,         32'h0000_3020, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 3'd2, 1'b0, 32'h0000_301C, 16'h0,    26'h0000C80, 32'h0,         32'h0000_3020, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 3'd2, 1'b0, 32'h0000_301C, 16'h0,    26'h0000C80, 32'h0,         32'h0000_3200, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 3'd5, 1'b1, 32'h0000_3000, 16'h0010, 26'h0,       32'h0000_5000, 32'h0000_3204, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 3'd3, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0000_6FFC, 32'h0000_6FFC, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 3'd0, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0000_6FFC, 1'b1, 32'h0000_7000};
        vecs[13] = '{1'b0, 3'd3, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0000_3000, 32'h0000_6FFC, 1'b1, 32'h0000_7000};
        vecs[14] = '{1'b1, 3'd0, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0000_6FFC, 1'b1, 32'h0000_7000};

        do_reset();
        check_state("reset", 32'h0000_3000, 1'b0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            stall = vecs[i].stall; jump_signal_id = vecs[i].js; branch_taken_id = vecs[i].bt;
            pc_id = vecs[i].pc_id; addr16_id = vecs[i].a16; addr26_id = vecs[i].a26;
            rs_value_id = vecs[i].rs;
            #1;
            check($sformatf("vec%0d.if_reg_enable", i), 32'(if_reg_enable), 32'(!vecs[i].stall));
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fault, vecs[i].e_fpc);
        end

        // Reset overrides FAULT even with inputs active
        stall = 1'b1; jump_signal_id = 3'd3; rs_value_id = 32'h0000_3002;
        do_reset();
        idle_inputs();
        check_state("rst_from_fault", 32'h0000_3000, 1'b0, 32'h0);

        // Misaligned jr target
        jump_signal_id = 3'd3; rs_value_id = 32'h0000_3002;
        tick();
        check_state("misaligned", 32'h0000_3000, 1'b1, 32'h0000_3002);
        idle_inputs();
        tick();
        check_state("frozen", 32'h0000_3000, 1'b1, 32'h0000_3002);

        // Branch just below the legal base
        do_reset();
        jump_signal_id = 3'd1; branch_taken_id = 1'b1; pc_id = 32'h0000_3000; addr16_id = 16'hFFFE;
        tick();
        check_state("below_base", 32'h0000_3000, 1'b1, 32'h0000_2FFC);

`ifdef FETCH_COUNTER_EN
        do_reset();
        idle_inputs();
        check("cnt.reset", fetch_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            stall = (i == 2 || i == 5 || i == 8);
            tick();
        end
        check("cnt.seven", fetch_count, 32'd7);
        stall = 1'b0; jump_signal_id = 3'd3; rs_value_id = 32'h0000_3001;
        tick();
        idle_inputs();
        tick();
        check("cnt.fault_hold", fetch_count, 32'd7);
`endif

        // Randomized traffic against the behavioural model
        do_reset();
        idle_inputs();
        m_pc = RST_PC; m_fault = 1'b0; m_fpc = 32'h0; m_cnt = 32'h0;
        for (int n = 0; n < 600; n++) begin
            reset           = ($urandom_range(0, 99) < (m_fault ? 25 : 2));
            stall           = ($urandom_range(0, 3) == 0);
            jump_signal_id  = 3'($urandom_range(0, 7));
            branch_taken_id = 1'($urandom_range(0, 1));
            pc_id           = m_pc - 32'd4;
            addr16_id       = 16'($urandom_range(0, 2047) - 1024);
            addr26_id       = 26'((BASE >> 2) + $urandom_range(0, 4200));
            rs_value_id     = ($urandom_range(0, 7) == 0) ? $urandom()
                              : BASE + 32'($urandom_range(0, 4200)) * 32'd4;
            #1;
            check("rnd.if_reg_enable", 32'(if_reg_enable), 32'(!stall));
            model_step();
            tick();
            check_state("rnd", m_pc, m_fault, m_fpc);
`ifdef FETCH_COUNTER_EN
            check("rnd.fetch_count", fetch_count, m_cnt);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
